pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
// - Owns the architectural fetch PC; feeds the fetch stage through a valid/ready handshake.
// - Consumes branch-execute results (taken flag + target) and redirects fetch.
// - Holds fetch and drives flush to kill wrong-path bundles in IF/ID for FLUSH_CYCLES cycles.
// - Sits downstream of branch execute and upstream of fetch, closing the control loop.
// PARAMETERS
// - RESET_PC      32'h0000_0000  fetch address after reset
// - BUNDLE_BYTES  8              sequential PC increment per accepted VLIW bundle
// - FLUSH_CYCLES  2              wrong-path bubble cycles after a redirect (>=1)
// PORTS
// - clk            in   1   single clock, rising edge
// - rst            in   1   synchronous, active-high reset
// - ex_valid       in   1   execute-stage result valid (low for NOP bundles)
// - ex_branch_taken in  1   branch/jump resolved taken
// - ex_new_pc      in   32  resolved target address
// - fetch_ready    in   1   fetch stage accepts fetch_pc this cycle
// - fetch_valid    out  1   fetch_pc is a valid request
// - fetch_pc       out  32  current fetch address
// - flush          out  1   kill all in-flight IF/ID bundles
// - redirect_cnt   out  32  taken-redirect count, saturates at 32'hFFFF_FFFF
// - fault          out  1   misaligned-target fault (BR_ALIGN_CHECK_EN only)
// BEHAVIOUR
// - States: BOOT, RUN, FLUSH, FAULT. All outputs registered.
// - Reset: state=BOOT, fetch_pc=RESET_PC, fetch_valid=0, flush=0, redirect_cnt=0, fault=0.
// - BOOT: one cycle, then RUN. fetch_valid rises the first cycle after rst deasserts.
// - RUN: fetch_valid=1. On fetch_valid&&fetch_ready, fetch_pc += BUNDLE_BYTES (mod 2^32, wraps silently).
//   If fetch_ready=0, fetch_pc holds and fetch_valid stays 1 (request never withdrawn).
// - Redirect: ex_valid&&ex_branch_taken. Next cycle: fetch_pc=ex_new_pc, state=FLUSH,
//   flush=1, fetch_valid=0, flush counter loaded with FLUSH_CYCLES-1, redirect_cnt+1.
// - A redirect beats a sequential increment in the same cycle. The accepted bundle is discarded.
// - ex_branch_taken with ex_valid=0 is ignored.
// - FLUSH: flush=1 and fetch_valid=0 while the counter is nonzero. The counter decrements each cycle.
//   At 0 it returns to RUN, and flush/fetch_valid update the next cycle. Total flush high = FLUSH_CYCLES cycles.
// - Redirect during FLUSH: the new target overwrites fetch_pc, the counter reloads, and the count increments.
// - fetch_ready is ignored in BOOT, FLUSH and FAULT.
// - rst in any state, including mid-FLUSH or FAULT, returns everything to the reset values next cycle.
// CONFIGURATION
// - Macro BR_ALIGN_CHECK_EN:
//   - Defined: a redirect with ex_new_pc[1:0]!=0 enters FAULT instead of FLUSH.
//     fault=1, fetch_valid=0, flush=1 (held), fetch_pc=offending target, redirect_cnt unchanged.
//     FAULT exits only on rst.
//   - Undefined: the target is forced to {ex_new_pc[31:2],2'b00}. fault is tied 0 and FAULT is unreachable.
// STRUCTURE
// - Shared package branch_pkg:
//   - redirect_state_t enum {BOOT,RUN,FLUSH,FAULT}
//   - PC_W=32
//   - default BUNDLE_BYTES
//   - default RESET_PC
// - One sub-module, redirect_flush_ctr: loadable down-counter, width $clog2(FLUSH_CYCLES)+1.
//   Inputs: load, load value. Output: done (count==0).
// - Saturating redirect counter and PC register live inline in the top module.
// TESTING
// - Sequential fetch: after reset, fetch_ready=1 for 4 cycles -> fetch_pc 0,8,16,24; fetch_valid=1 from cycle 1.
// - Backpressure: fetch_ready=0 for 3 cycles at pc=16 -> fetch_pc holds 16, fetch_valid stays 1.
// - Redirect: ex_valid=1, ex_branch_taken=1, ex_new_pc=32'h100 -> next cycle fetch_pc=32'h100.
//   flush=1 and fetch_valid=0 for exactly 2 cycles, then fetch 32'h100, 32'h108. redirect_cnt=1.
// - Back-to-back redirect: a second redirect to 32'h200 one cycle into FLUSH -> fetch_pc=32'h200.
//   flush lasts 2 more cycles, redirect_cnt=2.
// - Gating/wrap: ex_branch_taken=1 with ex_valid=0 -> no effect.
//   fetch_pc=32'hFFFF_FFF8 accepted -> fetch_pc=32'h0.
//   rst asserted mid-FLUSH -> all reset values next cycle.
// - Alignment: ex_new_pc=32'h102. With BR_ALIGN_CHECK_EN: fault=1, fetch_valid=0 until rst.
//   Without: fetch_pc=32'h100, fault=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and defaults for the PC redirect unit.
package branch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_BUNDLE_BYTES = 8;
  localparam int unsigned DEFAULT_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FAULT = 2'd3
  } redirect_state_t;

endpackage

// File: rtl/redirect_flush_ctr.sv
// Loadable down-counter that times the wrong-path flush window.
// It counts down to zero and then holds there. done is high while the count is zero.
module redirect_flush_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // load takes priority; otherwise decrement until the terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequential bundle fetch, branch redirect with flush window.
// Optional macro BR_ALIGN_CHECK_EN: misaligned redirect targets trap into FAULT.
// Without that macro, misaligned targets are silently word-aligned.
//
// state | meaning
// BOOT  | one cycle after reset, no fetch request
// RUN   | sequential fetch, fetch_pc advances on each accepted bundle
// FLUSH | fetch held, flush asserted while wrong-path bundles drain
// FAULT | misaligned redirect trapped, left only through rst
module pc_redirect_unit
  import branch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned     BUNDLE_BYTES = DEFAULT_BUNDLE_BYTES,
  parameter int unsigned     FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_branch_taken,
  input  logic [PC_W-1:0] ex_new_pc,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_pc,
  output logic            flush,
  output logic [31:0]     redirect_cnt,
  output logic            fault
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

  redirect_state_t state;
  logic            redirect;
  logic            ctr_load;
  logic            ctr_done;
  logic            misaligned;
  logic [PC_W-1:0] target;

  // a taken branch only redirects once fetch is live; BOOT and FAULT ignore it
  always_comb begin
    redirect = ex_valid && ex_branch_taken && ((state == RUN) || (state == FLUSH));
`ifdef BR_ALIGN_CHECK_EN
    misaligned = (ex_new_pc[1:0] != 2'b00);
    target     = ex_new_pc;
`else
    misaligned = 1'b0;
    target     = ex_new_pc & ~PC_W'(3);
`endif
    ctr_load = redirect && !misaligned;
  end

  redirect_flush_ctr #(
    .W (CW)
  ) u_flush_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (ctr_load),
    .load_value (FLUSH_LOAD),
    .done       (ctr_done)
  );

  // control FSM with registered outputs, PC register and saturating redirect count
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      fetch_valid  <= 1'b0;
      flush        <= 1'b0;
      redirect_cnt <= '0;
      fault        <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN, FLUSH: begin
          if (redirect) begin
            // the redirect beats any sequential advance; an accepted bundle is dropped
            fetch_pc    <= target;
            fetch_valid <= 1'b0;
            flush       <= 1'b1;
            if (misaligned) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= FLUSH;
              if (redirect_cnt != 32'hFFFF_FFFF) begin
                redirect_cnt <= redirect_cnt + 32'd1;
              end
            end
          end else if (state == RUN) begin
            if (fetch_valid && fetch_ready) begin
              fetch_pc <= fetch_pc + PC_W'(BUNDLE_BYTES);
            end
          end else if (ctr_done) begin
            state       <= RUN;
            flush       <= 1'b0;
            fetch_valid <= 1'b1;
          end
        end
        default: begin
          // FAULT: everything is held until reset
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed checks for pc_redirect_unit with default parameters.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_branch_taken;
  logic [31:0] ex_new_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic [31:0] redirect_cnt;
  logic        fault;

  int total = 0;
  int bad   = 0;

  pc_redirect_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_branch_taken (ex_branch_taken),
    .ex_new_pc       (ex_new_pc),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .flush           (flush),
    .redirect_cnt    (redirect_cnt),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                         input logic fl, input logic [31:0] cnt, input logic flt);
    chk({tag, ".pc"}, fetch_pc, pc);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'(v));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".cnt"}, redirect_cnt, cnt);
    chk({tag, ".fault"}, 32'(fault), 32'(flt));
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    ex_valid = 1'b1; ex_branch_taken = 1'b1; ex_new_pc = tgt;
    step();
    ex_valid = 1'b0; ex_branch_taken = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_branch_taken = 1'b0; ex_new_pc = '0; fetch_ready = 1'b0;
    step(); step();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);

    // sequential fetch
    rst = 1'b0; fetch_ready = 1'b1;
    step(); chk_all("boot", 32'h0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(); chk_all("seq8", 32'h8, 1'b1, 1'b0, 32'd0, 1'b0);
    step(); chk_all("seq16", 32'h10, 1'b1, 1'b0, 32'd0, 1'b0);

    // backpressure at 16
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall", 32'h10, 1'b1, 1'b0, 32'd0, 1'b0);
    end
    fetch_ready = 1'b1;
    step(); chk_all("seq24", 32'h18, 1'b1, 1'b0, 32'd0, 1'b0);

    // redirect beats the accepted bundle, flush lasts two cycles
    redirect_to(32'h100); chk_all("redir1", 32'h100, 1'b0, 1'b1, 32'd1, 1'b0);
    step(); chk_all("flush1b", 32'h100, 1'b0, 1'b1, 32'd1, 1'b0);
    step(); chk_all("run100", 32'h100, 1'b1, 1'b0, 32'd1, 1'b0);
    step(); chk_all("run108", 32'h108, 1'b1, 1'b0, 32'd1, 1'b0);

    // back-to-back redirect one cycle into FLUSH
    redirect_to(32'h300); chk_all("redir2", 32'h300, 1'b0, 1'b1, 32'd2, 1'b0);
    redirect_to(32'h200); chk_all("redir3", 32'h200, 1'b0, 1'b1, 32'd3, 1'b0);
    step(); chk_all("flush3b", 32'h200, 1'b0, 1'b1, 32'd3, 1'b0);
    step(); chk_all("run200", 32'h200, 1'b1, 1'b0, 32'd3, 1'b0);

    // taken without ex_valid is ignored
    ex_valid = 1'b0; ex_branch_taken = 1'b1; ex_new_pc = 32'h400;
    step(); chk_all("gated", 32'h208, 1'b1, 1'b0, 32'd3, 1'b0);
    ex_branch_taken = 1'b0;

    // sequential wrap
    redirect_to(32'hFFFF_FFF8); chk_all("redirw", 32'hFFFF_FFF8, 1'b0, 1'b1, 32'd4, 1'b0);
    step(); step(); chk_all("runw", 32'hFFFF_FFF8, 1'b1, 1'b0, 32'd4, 1'b0);
    step(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 32'd4, 1'b0);

    // misaligned target
    redirect_to(32'h102);
`ifdef BR_ALIGN_CHECK_EN
    chk_all("fault", 32'h102, 1'b0, 1'b1, 32'd4, 1'b1);
    step(); step(); chk_all("faulthold", 32'h102, 1'b0, 1'b1, 32'd4, 1'b1);
`else
    chk_all("align", 32'h100, 1'b0, 1'b1, 32'd5, 1'b0);
`endif

    // reset while mid-FLUSH (or in FAULT)
    rst = 1'b1;
    step(); chk_all("rstmid", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    step(); chk_all("reboot", 32'h0, 1'b1, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
